// File: rtl/calculator_arbiter_if.sv
// calculator_arbiter_if: requester, calculator and response bundle.
// Ports: en, req_*, calc_*, rsp_*, busy (+ rsp_zdiv under CALC_ZDIV_FLAG_EN).
interface calculator_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic                 en;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [2*NUM_REQ-1:0] req_func;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic [1:0]           calc_func;
  logic [7:0]           calc_a;
  logic [7:0]           calc_b;
  logic [15:0]          calc_out;
  logic                 rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic [15:0]          rsp_data;
  logic                 busy;
`ifdef CALC_ZDIV_FLAG_EN
  logic                 rsp_zdiv;
`endif

  modport slave (
    input  en, req_valid, req_func, req_a, req_b, calc_out,
    output req_ready, calc_func, calc_a, calc_b,
    output rsp_valid, rsp_id, rsp_data, busy
`ifdef CALC_ZDIV_FLAG_EN
    , output rsp_zdiv
`endif
  );

  modport master (
    output en, req_valid, req_func, req_a, req_b, calc_out,
    input  req_ready, calc_func, calc_a, calc_b,
    input  rsp_valid, rsp_id, rsp_data, busy
`ifdef CALC_ZDIV_FLAG_EN
    , input rsp_zdiv
`endif
  );
endinterface

// File: rtl/calculator_arbiter.sv
// calculator_arbiter: round-robin share of one pipelined calculator.
// Ports: clk, rst (async, active high), bus (calculator_arbiter_if.slave).
// Optional: CALC_ZDIV_FLAG_EN adds bus.rsp_zdiv (divide-by-zero tag).
module calculator_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 3,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input logic clk,
  input logic rst,
  calculator_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W-1:0]    idx;
  logic [NUM_REQ-1:0] gnt;
  logic               accept;

  logic [1:0] g_func;
  logic [7:0] g_a;
  logic [7:0] g_b;

  logic [1:0] cf_q;
  logic [7:0] ca_q;
  logic [7:0] cb_q;

  // One stage per cycle from accept to response capture.
  logic [LATENCY:0]           tag_v;
  logic [LATENCY:0][ID_W-1:0] tag_id;

  logic            rv_q;
  logic [ID_W-1:0] rid_q;
  logic [15:0]     rd_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (!bus.en) state_d = DRAIN;
      DRAIN: begin
        if (bus.en)      state_d = RUN;
        else if (~|tag_v) state_d = IDLE;
      end
      IDLE:    if (bus.en) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = '0;
    accept = 1'b0;
    if (state_q == RUN && bus.en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
        if (!accept && bus.req_valid[idx]) begin
          accept   = 1'b1;
          gnt[idx] = 1'b1;
          gnt_id   = idx;
        end
      end
    end
  end

  assign g_func = bus.req_func[{gnt_id, 1'b0} +: 2];
  assign g_a    = bus.req_a[{gnt_id, 3'b000} +: 8];
  assign g_b    = bus.req_b[{gnt_id, 3'b000} +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      ptr_q   <= '0;
      cf_q    <= '0;
      ca_q    <= '0;
      cb_q    <= '0;
      tag_v   <= '0;
      tag_id  <= '0;
      rv_q    <= 1'b0;
      rid_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cf_q  <= g_func;
        ca_q  <= g_a;
        cb_q  <= g_b;
        ptr_q <= (gnt_id == ID_W'(NUM_REQ - 1))
               ? '0 : gnt_id + 1'b1;
      end
      tag_v  <= {tag_v[LATENCY-1:0], accept};
      tag_id <= {tag_id[LATENCY-1:0], gnt_id};
      rv_q   <= tag_v[LATENCY];
      if (tag_v[LATENCY]) begin
        rid_q <= tag_id[LATENCY];
        rd_q  <= bus.calc_out;
      end
    end
  end

`ifdef CALC_ZDIV_FLAG_EN
  logic [LATENCY:0] tag_z;
  logic             rz_q;
  logic             zdiv;

  assign zdiv = (g_func == 2'b11) && (g_b == 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_z <= '0;
      rz_q  <= 1'b0;
    end else begin
      tag_z <= {tag_z[LATENCY-1:0], accept & zdiv};
      rz_q  <= tag_v[LATENCY] & tag_z[LATENCY];
    end
  end

  assign bus.rsp_zdiv = rz_q;
`endif

  assign bus.req_ready = gnt;
  assign bus.calc_func = cf_q;
  assign bus.calc_a    = ca_q;
  assign bus.calc_b    = cb_q;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_id    = rid_q;
  assign bus.rsp_data  = rd_q;
  assign bus.busy      = |tag_v;
endmodule

// File: tb/tb_calculator_arbiter.sv
// tb_calculator_arbiter: random + directed bench with a queue model.
// Drives requesters, emulates the calculator, compares every cycle.
module tb_calculator_arbiter;
  localparam int N   = 4;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  calculator_arbiter_if #(.NUM_REQ(N)) bus();

  calculator_arbiter #(
    .NUM_REQ(N),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h @%0t", name, act, exp, $time);
    end
  endtask

  // Calculator behaviour: add, sub, mul, div with saturating /0.
  function automatic logic [15:0] calc(input logic [1:0] f,
                                       input logic signed [7:0] a,
                                       input logic signed [7:0] b);
    int r;
    case (f)
      2'b00: r = int'(a) + int'(b);
      2'b01: r = int'(a) - int'(b);
      2'b10: r = int'(a) * int'(b);
      default: begin
        if (b == 0) r = (a >= 0) ? 32767 : -32768;
        else        r = int'(a) / int'(b);
      end
    endcase
    return r[15:0];
  endfunction

  // Calculator emulation: samples calc_* and delivers LAT cycles later.
  logic [15:0] cpipe [LAT];
  always @(posedge clk) begin
    cpipe[0] <= calc(bus.calc_func, bus.calc_a, bus.calc_b);
    for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
  end
  assign bus.calc_out = cpipe[LAT-1];

  // Reference model: pointer, run flag, queue of in-flight results.
  typedef struct {
    int          due;
    int          id;
    logic [15:0] data;
    logic        z;
  } ent_t;

  ent_t        q[$];
  int          m_ptr = 0;
  logic        m_run = 1'b1;
  int          cyc   = 0;
  logic        e_rv  = 1'b0;
  int          e_id  = 0;
  logic [15:0] e_data = '0;
  logic        e_z   = 1'b0;
  logic [1:0]  e_cf  = '0;
  logic [7:0]  e_ca  = '0;
  logic [7:0]  e_cb  = '0;

  function automatic int model_grant();
    if (!m_run || bus.en !== 1'b1) return -1;
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (bus.req_valid[i] === 1'b1) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] gvec();
    logic [N-1:0] v;
    int g;
    v = '0;
    g = model_grant();
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_ptr = 0; m_run = 1'b1; cyc = 0;
      e_rv = 1'b0; e_id = 0; e_data = '0; e_z = 1'b0;
      e_cf = '0; e_ca = '0; e_cb = '0;
    end else begin
      int   g;
      ent_t e;
      g = model_grant();
      cyc++;
      e_rv = 1'b0;
      e_z  = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e_rv   = 1'b1;
        e_id   = q[0].id;
        e_data = q[0].data;
        e_z    = q[0].z;
        void'(q.pop_front());
      end
      if (g >= 0) begin
        e_cf   = bus.req_func[2*g +: 2];
        e_ca   = bus.req_a[8*g +: 8];
        e_cb   = bus.req_b[8*g +: 8];
        e.due  = cyc + LAT + 1;
        e.id   = g;
        e.data = calc(e_cf, e_ca, e_cb);
        e.z    = (e_cf == 2'b11) && (e_cb == 8'd0);
        q.push_back(e);
        m_ptr  = (g + 1) % N;
      end
      m_run = bus.en;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("req_ready", bus.req_ready, gvec());
      chk("rsp_valid", bus.rsp_valid, e_rv);
      chk("rsp_id", bus.rsp_id, e_id);
      chk("rsp_data", bus.rsp_data, e_data);
      chk("busy", bus.busy, q.size() > 0);
      chk("calc_func", bus.calc_func, e_cf);
      chk("calc_a", bus.calc_a, e_ca);
      chk("calc_b", bus.calc_b, e_cb);
`ifdef CALC_ZDIV_FLAG_EN
      chk("rsp_zdiv", bus.rsp_zdiv, e_z);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [1:0] f,
                         input logic [7:0] a, input logic [7:0] b);
    bus.req_func[2*i +: 2] = f;
    bus.req_a[8*i +: 8]    = a;
    bus.req_b[8*i +: 8]    = b;
  endtask

  task automatic clr_inputs();
    bus.req_valid = '0;
    bus.req_func  = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
  endtask

  int ids[$];
  int pulses;
  int hold;

  initial begin
    rst    = 1'b1;
    bus.en = 1'b1;
    clr_inputs();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_calc_a", bus.calc_a, 0);

    // Single request from requester 2: 5 + 3.
    set_req(2, 2'b00, 8'd5, 8'd3);
    bus.req_valid = 4'b0100;
    #1;
    chk("t1_ready", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = '0;
    repeat (3) tick();
    chk("t1_early", bus.rsp_valid, 0);
    tick();
    chk("t1_rsp_valid", bus.rsp_valid, 1);
    chk("t1_rsp_id", bus.rsp_id, 2);
    chk("t1_rsp_data", bus.rsp_data, 16'd8);

    // All four valid for 8 cycles.
    tick();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 2'(i), 8'(i + 1), 8'(7 - i));
    bus.req_valid = 4'b1111;
    ids.delete();
    for (int c = 0; c < 14; c++) begin
      #1;
      if (c < 8) chk("rr_grant", bus.req_ready, 4'b0001 << (c % 4));
      if (bus.rsp_valid) ids.push_back(int'(bus.rsp_id));
      chk("rr_rsp_slot", bus.rsp_valid, (c >= 5 && c <= 12));
      tick();
      if (c == 7) bus.req_valid = '0;
    end
    chk("rr_count", ids.size(), 8);
    foreach (ids[k]) chk("rr_order", ids[k], k % 4);

    // Divide by zero from requester 1.
    do_reset();
    clr_inputs();
    set_req(1, 2'b11, 8'h10, 8'h00);
    bus.req_valid = 4'b0010;
    tick();
    set_req(1, 2'b11, 8'hF0, 8'h00);
    tick();
    bus.req_valid = '0;
    repeat (3) tick();
    chk("zd_pos_valid", bus.rsp_valid, 1);
    chk("zd_pos_data", bus.rsp_data, 16'h7FFF);
`ifdef CALC_ZDIV_FLAG_EN
    chk("zd_pos_flag", bus.rsp_zdiv, 1);
`endif
    tick();
    chk("zd_neg_data", bus.rsp_data, 16'h8000);
`ifdef CALC_ZDIV_FLAG_EN
    chk("zd_neg_flag", bus.rsp_zdiv, 1);
`endif

    // Drain: three accepts then en low.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 2'b10, 8'(3 * i + 2), 8'hFD);
    bus.req_valid = 4'b1111;
    repeat (3) tick();
    bus.en = 1'b0;
    #1;
    chk("dr_ready_off", bus.req_ready, 0);
    pulses = 0;
    repeat (8) begin
      tick();
      if (bus.rsp_valid) pulses++;
    end
    chk("dr_pulses", pulses, 3);
    chk("dr_busy", bus.busy, 0);
    bus.en = 1'b1;
    #1;
    chk("dr_idle_ready", bus.req_ready, 0);
    tick();
    chk("dr_resume", bus.req_ready, 4'b1000);
    bus.req_valid = '0;
    repeat (6) tick();

    // Reset while two ops are in flight.
    do_reset();
    bus.req_valid = 4'b1111;
    repeat (2) tick();
    bus.req_valid = '0;
    tick();
    rst = 1'b1;
    #1;
    chk("mr_busy", bus.busy, 0);
    chk("mr_calc_func", bus.calc_func, 0);
    chk("mr_calc_a", bus.calc_a, 0);
    chk("mr_rsp_data", bus.rsp_data, 0);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      tick();
      if (bus.rsp_valid) pulses++;
    end
    chk("mr_no_rsp", pulses, 0);
    bus.req_valid = 4'b1111;
    #1;
    chk("mr_next_grant", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    repeat (6) tick();

    // Only requester 3: granted every cycle, responses back-to-back.
    do_reset();
    set_req(3, 2'b01, 8'h40, 8'h11);
    bus.req_valid = 4'b1000;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (c < 6) chk("wr_grant", bus.req_ready, 4'b1000);
      chk("wr_rsp", bus.rsp_valid, (c >= 5 && c <= 10));
      tick();
      if (c == 5) bus.req_valid = '0;
    end

    // Random traffic.
    hold = 0;
    repeat (1500) begin
      if (hold == 0) begin
        bus.en = ($urandom_range(0, 3) != 0);
        hold   = $urandom_range(1, 8);
      end
      hold--;
      bus.req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++)
        set_req(i, 2'($urandom_range(0, 3)), 8'($urandom),
                ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom));
      if ($urandom_range(0, 299) == 0) do_reset();
      tick();
    end
    bus.en = 1'b1;
    clr_inputs();
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
